// File: rtl/key_scan_ctrl.sv
// Purpose : matrix keypad scanner: strobes one-cold columns, debounces a closed
//           key, hands its code to a consumer and waits for the key to be released.
// Latency : row_n fall -> latch_en <= 2 + SCAN_DIV*COLS + DEBOUNCE + 1 clk cycles.
// Backpr. : no stall; data_ready stays high until data_ack; a new key overwrites and flags overrun.
// Ports   : clk (state on falling edge), rst (sync, active-high), row_n[ROWS] raw rows (active-low),
//           col_n[COLS] one-cold strobes, key_code = row*COLS+col, latch_en load pulse,
//           data_ready / data_ack consumer handshake, overrun sticky lost-key flag.
module key_scan_ctrl #(
  parameter  int ROWS     = 4,
  parameter  int COLS     = 4,
  parameter  int SCAN_DIV = 1000,
  parameter  int DEBOUNCE = 16,
  localparam int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              latch_en,
  output logic              data_ready,
  input  logic              data_ack,
  output logic              overrun
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_SCAN  = 2'd0;
  localparam logic [1:0] S_DEB   = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [NW-1:0] CNT_LAST   = NW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [ROWS-1:0]   rs1_q, rs_q;
  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [COLS-1:0]   col_n_q, col_n_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              data_ready_q, data_ready_d;
  logic              overrun_q, overrun_d;

  logic [CW-1:0]     col_inc;
  logic [RW-1:0]     low_row;
  logic              any_low;
  logic              row_bit;
  logic [CODE_W-1:0] code_now;

  assign col_inc  = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
  assign any_low  = ~&rs_q;
  assign row_bit  = rs_q[row_q];
  assign code_now = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);

  // Descending scan so the last assignment is the lowest-index closed row.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_row = RW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_low) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = S_DEB;
          end else begin
            col_d = col_inc;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      S_DEB: begin
        if (!row_bit) begin
          if (cnt_q == CNT_LAST) state_d = S_LATCH;
          else                   cnt_d   = cnt_q + NW'(1);
        end else begin
          // Bounce: give up on this column and move on.
          state_d = S_SCAN;
          col_d   = col_inc;
          dwell_d = '0;
        end
      end
      S_LATCH: begin
        state_d = S_REL;
        cnt_d   = '0;
      end
      S_REL: begin
        // Only the captured row is watched; other keys are ignored here.
        if (row_bit) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_SCAN;
            col_d   = col_inc;
            dwell_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = S_SCAN;
        dwell_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe is registered from col_d so the output pins never glitch.
  assign col_n_d = ~(COLS'(1) << col_d);

  always_comb begin
    key_code_d   = key_code_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    if (state_q == S_LATCH) begin
      key_code_d   = code_now;
      data_ready_d = 1'b1;
      // An ack on the latch cycle consumes the old key, so nothing is lost.
      if (data_ready_q && !data_ack) overrun_d = 1'b1;
      else if (data_ack)             overrun_d = 1'b0;
    end else if (data_ack) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      rs1_q        <= '1;
      rs_q         <= '1;
      state_q      <= S_SCAN;
      dwell_q      <= '0;
      cnt_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      col_n_q      <= ~COLS'(1);
      key_code_q   <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rs1_q        <= row_n;
      rs_q         <= rs1_q;
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      col_n_q      <= col_n_d;
      key_code_q   <= key_code_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign col_n      = col_n_q;
  assign key_code   = key_code_q;
  assign latch_en   = (state_q == S_LATCH);
  assign data_ready = data_ready_q;
  assign overrun    = overrun_q;

endmodule
